// File: rtl/fsm_out_pkg_hdl.sv
`default_nettype none
// ============================================================================
// Module      : fsm_out_pkg_hdl
// Description : Shared typedefs and width constants for the fsm_out event
//               logger: the event record layout and its packed width.
// Revision    : 1.0 - initial release
// ============================================================================
package fsm_out_pkg_hdl;

  localparam int FSM_STATE_W = 3;
  localparam int FSM_OUT_W   = 4;
  localparam int FSM_TS_W    = 16;

  // One logged transition: new state, new outputs, cycles since last event.
  typedef struct packed {
    logic [FSM_STATE_W-1:0] state;
    logic [FSM_OUT_W-1:0]   out;
    logic [FSM_TS_W-1:0]    delta;
  } fsm_evt_t;

  localparam int FSM_EVT_W = $bits(fsm_evt_t);

endpackage : fsm_out_pkg_hdl
`default_nettype wire

// File: rtl/fsm_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fsm_evt_fifo
// Description : Synchronous show-ahead FIFO for event records. Pointers carry
//               one extra wrap bit so full/empty fall out of a subtraction.
//               Head data reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_evt_fifo
  import fsm_out_pkg_hdl::*;
#(
  parameter int W     = FSM_EVT_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic         do_push;
  logic         do_pop;

  assign count_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (count_o == FULL_CNT);

  // A pop frees a slot in the same cycle, so push into a full FIFO is legal then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  // Pointer update; flush simply collapses both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage array; no reset needed since empty slots are never presented.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule : fsm_evt_fifo
`default_nettype wire

// File: rtl/fsm_out_event_logger.sv
`default_nettype none
// ============================================================================
// Module      : fsm_out_event_logger
// Description : Watches the FSM state/output pair, records every change with
//               the enabled-cycle delta since the previous change, and queues
//               the records for a valid/ready consumer. Sticky overflow flags
//               records lost to a full queue.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_out_event_logger
  import fsm_out_pkg_hdl::*;
#(
  parameter int STATE_W = FSM_STATE_W,
  parameter int OUT_W   = FSM_OUT_W,
  parameter int TS_W    = FSM_TS_W,
  parameter int DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic                    clr_i,
  input  logic [STATE_W-1:0]      fsm_state_i,
  input  logic [OUT_W-1:0]        fsm_out_i,
  output logic                    evt_valid_o,
  input  logic                    evt_ready_i,
  output logic [STATE_W-1:0]      evt_state_o,
  output logic [OUT_W-1:0]        evt_out_o,
  output logic [TS_W-1:0]         evt_delta_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o
);

  localparam int REC_W = STATE_W + OUT_W + TS_W;

  logic [STATE_W-1:0] prev_state_q;
  logic [OUT_W-1:0]   prev_out_q;
  logic [TS_W-1:0]    delta_cnt_q;
  logic [TS_W-1:0]    delta_d;
  logic               overflow_q;

  logic               chg;
  logic               push;
  logic               pop;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [REC_W-1:0]   rec_in;
  logic [REC_W-1:0]   rec_out;

  assign chg = enable_i &&
               ({fsm_state_i, fsm_out_i} != {prev_state_q, prev_out_q});

  // Saturating +1: the delta pins at all-ones rather than wrapping.
  assign delta_d = (delta_cnt_q == '1) ? delta_cnt_q : delta_cnt_q + 1'b1;

  assign evt_valid_o = !fifo_empty;
  assign pop         = evt_valid_o && evt_ready_i && !clr_i;
  assign push        = chg && !clr_i;
  assign drop        = push && fifo_full && !pop;
  assign rec_in      = {fsm_state_i, fsm_out_i, delta_d};

  // Change tracking, delta counter and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_state_q <= '0;
      prev_out_q   <= '0;
      delta_cnt_q  <= '0;
      overflow_q   <= 1'b0;
    end else if (clr_i) begin
      prev_state_q <= fsm_state_i;
      prev_out_q   <= fsm_out_i;
      delta_cnt_q  <= '0;
      overflow_q   <= 1'b0;
    end else if (enable_i) begin
      prev_state_q <= fsm_state_i;
      prev_out_q   <= fsm_out_i;
      // An event restarts the count even when its record is dropped.
      delta_cnt_q  <= chg ? '0 : delta_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign overflow_o = overflow_q;

  fsm_evt_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (rec_in),
    .pop_i   (pop),
    .flush_i (clr_i),
    .data_o  (rec_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  assign {evt_state_o, evt_out_o, evt_delta_o} = rec_out;

endmodule : fsm_out_event_logger
`default_nettype wire

// File: tb/tb_fsm_out_event_logger.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_out_event_logger
// Description : Directed bench for fsm_out_event_logger. Stimulus pushes the
//               hand-computed record into a scoreboard queue; a monitor pops
//               and compares each record the DUT hands over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_out_event_logger;
  import fsm_out_pkg_hdl::*;

  logic                   clk;
  logic                   rst_n;
  logic                   enable_i;
  logic                   clr_i;
  logic [FSM_STATE_W-1:0] fsm_state_i;
  logic [FSM_OUT_W-1:0]   fsm_out_i;
  logic                   evt_valid_o;
  logic                   evt_ready_i;
  logic [FSM_STATE_W-1:0] evt_state_o;
  logic [FSM_OUT_W-1:0]   evt_out_o;
  logic [FSM_TS_W-1:0]    evt_delta_o;
  logic [3:0]             count_o;
  logic                   overflow_o;

  int checks = 0;
  int errors = 0;
  fsm_evt_t sb[$];

  fsm_out_event_logger #(
    .STATE_W (FSM_STATE_W),
    .OUT_W   (FSM_OUT_W),
    .TS_W    (FSM_TS_W),
    .DEPTH   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable_i    (enable_i),
    .clr_i       (clr_i),
    .fsm_state_i (fsm_state_i),
    .fsm_out_i   (fsm_out_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_state_o (evt_state_o),
    .evt_out_o   (evt_out_o),
    .evt_delta_o (evt_delta_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic sb_push(input logic [2:0] s, input logic [3:0] o, input logic [15:0] d);
    fsm_evt_t e;
    e.state = s;
    e.out   = o;
    e.delta = d;
    sb.push_back(e);
  endtask

  // Monitor: every accepted head record must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && evt_valid_o && evt_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got state=%0d out=%0d delta=%0d, none expected",
                 evt_state_o, evt_out_o, evt_delta_o);
      end else begin
        fsm_evt_t e;
        e = sb.pop_front();
        if (evt_state_o !== e.state || evt_out_o !== e.out || evt_delta_o !== e.delta) begin
          errors++;
          $display("FAIL record: got state=%0d out=%0d delta=%0d expected state=%0d out=%0d delta=%0d",
                   evt_state_o, evt_out_o, evt_delta_o, e.state, e.out, e.delta);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; enable_i = 1'b0; clr_i = 1'b0;
    fsm_state_i = '0; fsm_out_i = '0; evt_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    step(2);
    chk("rst_valid", evt_valid_o, 0);
    chk("rst_state", evt_state_o, 0);
    chk("rst_out", evt_out_o, 0);
    chk("rst_delta", evt_delta_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_ovf", overflow_o, 0);

    // Idle for 10 enabled cycles, then a change reports delta 11.
    rst_n = 1'b1; enable_i = 1'b1;
    step(10);
    chk("idle_count", count_o, 0);
    chk("idle_valid", evt_valid_o, 0);
    fsm_state_i = 3'd2; fsm_out_i = 4'd5; sb_push(3'd2, 4'd5, 16'd11);
    step(1);
    chk("first_valid", evt_valid_o, 1);
    chk("first_count", count_o, 1);
    chk("first_delta", evt_delta_o, 11);
    evt_ready_i = 1'b1; step(1); evt_ready_i = 1'b0;
    chk("first_drained", count_o, 0);

    // Three back-to-back changes, then drain in order.
    clr_i = 1'b1; step(1); clr_i = 1'b0;
    fsm_state_i = 3'd1; fsm_out_i = 4'd1; sb_push(3'd1, 4'd1, 16'd1); step(1);
    fsm_state_i = 3'd3; fsm_out_i = 4'd2; sb_push(3'd3, 4'd2, 16'd1); step(1);
    fsm_state_i = 3'd4; fsm_out_i = 4'd7; sb_push(3'd4, 4'd7, 16'd1); step(1);
    chk("three_count", count_o, 3);
    evt_ready_i = 1'b1; step(3); evt_ready_i = 1'b0;
    chk("three_drained", count_o, 0);
    chk("three_valid", evt_valid_o, 0);

    // Fill, overflow by two, then push+pop while full.
    clr_i = 1'b1; step(1); clr_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      fsm_state_i = 3'(i); fsm_out_i = 4'(i);
      sb_push(3'(i), 4'(i), 16'd1);
      step(1);
    end
    chk("fill_count", count_o, 8);
    chk("fill_ovf", overflow_o, 0);
    fsm_state_i = 3'd1; fsm_out_i = 4'd9;  step(1);
    fsm_state_i = 3'd2; fsm_out_i = 4'd10; step(1);
    chk("drop_count", count_o, 8);
    chk("drop_ovf", overflow_o, 1);
    fsm_state_i = 3'd3; fsm_out_i = 4'd11; evt_ready_i = 1'b1;
    sb_push(3'd3, 4'd11, 16'd1);
    step(1);
    chk("pushpop_count", count_o, 8);
    chk("pushpop_ovf", overflow_o, 1);
    step(8); evt_ready_i = 1'b0;
    chk("full_drained", count_o, 0);
    chk("ovf_sticky", overflow_o, 1);

    // Enable low freezes delta and suppresses events.
    clr_i = 1'b1; step(1); clr_i = 1'b0;
    chk("clr_ovf", overflow_o, 0);
    step(3);
    enable_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      fsm_state_i = 3'(i); fsm_out_i = 4'(15 - i);
      step(1);
    end
    chk("dis_count", count_o, 0);
    chk("dis_valid", evt_valid_o, 0);
    fsm_state_i = 3'd5; fsm_out_i = 4'd3; enable_i = 1'b1;
    sb_push(3'd5, 4'd3, 16'd4);
    step(1);
    chk("en_count", count_o, 1);
    evt_ready_i = 1'b1; step(1); evt_ready_i = 1'b0;

    // Clear with four entries and overflow set.
    clr_i = 1'b1; step(1); clr_i = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      fsm_state_i = 3'(i); fsm_out_i = 4'(15 - i);
      if (i <= 8) sb_push(3'(i), 4'(15 - i), 16'd1);
      step(1);
    end
    chk("pre_clr_ovf", overflow_o, 1);
    evt_ready_i = 1'b1; step(4); evt_ready_i = 1'b0;
    chk("pre_clr_count", count_o, 4);
    fsm_state_i = 3'd6; fsm_out_i = 4'd6; clr_i = 1'b1;
    step(1); clr_i = 1'b0;
    sb.delete();
    chk("clr_count", count_o, 0);
    chk("clr_ovf2", overflow_o, 0);
    chk("clr_valid", evt_valid_o, 0);
    step(1);
    chk("post_clr_count", count_o, 0);

    // Saturating delta.
    step(70000);
    fsm_state_i = 3'd7; fsm_out_i = 4'd1; sb_push(3'd7, 4'd1, 16'hFFFF);
    step(1);
    chk("sat_delta", evt_delta_o, 32'hFFFF);
    evt_ready_i = 1'b1; step(1); evt_ready_i = 1'b0;

    // Asynchronous reset mid-drain.
    clr_i = 1'b1; step(1); clr_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      fsm_state_i = 3'(i); fsm_out_i = 4'(i + 1);
      sb_push(3'(i), 4'(i + 1), 16'd1);
      step(1);
    end
    chk("rd_count", count_o, 5);
    evt_ready_i = 1'b1; step(2);
    #1 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_valid", evt_valid_o, 0);
    chk("arst_state", evt_state_o, 0);
    chk("arst_out", evt_out_o, 0);
    chk("arst_delta", evt_delta_o, 0);
    chk("arst_count", count_o, 0);
    chk("arst_ovf", overflow_o, 0);
    evt_ready_i = 1'b0; enable_i = 1'b0;
    step(2);
    fsm_state_i = 3'd2; fsm_out_i = 4'd3; enable_i = 1'b1; rst_n = 1'b1;
    sb_push(3'd2, 4'd3, 16'd1);
    step(1);
    chk("post_rst_count", count_o, 1);
    evt_ready_i = 1'b1; step(1); evt_ready_i = 1'b0;
    chk("post_rst_drained", count_o, 0);
    step(2);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fsm_out_event_logger
`default_nettype wire
